// File: rtl/result_fifo_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : result_fifo_ctl                                            |
// | Description : Parametrised result buffer between the CORDIC core output  |
// |               and the AHB-Lite slave read path. Provides backpressure,   |
// |               fill level, almost-full threshold, sticky overflow and     |
// |               underflow flags, synchronous flush, and either             |
// |               first-word-fall-through or registered-read output.         |
// | Ports       : clk, reset             - clock, synchronous active-high rst |
// |               valid_out_interface,   - push strobe / push data from core |
// |               out_interface                                              |
// |               ready_to_core          - slot available (!full)            |
// |               read_fifo_en           - pop strobe from bus slave         |
// |               out_fifo, rd_valid     - read data and its valid qualifier |
// |               empty, full,           - occupancy status (registered-     |
// |               almost_full, level       state derived only)               |
// |               flush, clear_flags     - discard entries / clear flags     |
// |               overflow, underflow    - sticky error flags                |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module result_fifo_ctl #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int AF_TH  = 6,
  parameter int FWFT   = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_out_interface,
  input  logic [DATA_W-1:0]          out_interface,
  output logic                       ready_to_core,
  input  logic                       read_fifo_en,
  output logic [DATA_W-1:0]          out_fifo,
  output logic                       rd_valid,
  output logic                       empty,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     level,
  input  logic                       flush,
  input  logic                       clear_flags,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int c_ADDR_W = $clog2(DEPTH);
  localparam int c_LVL_W  = c_ADDR_W + 1;

  logic [DATA_W-1:0]   r_mem [DEPTH];
  logic [c_ADDR_W-1:0] r_wr_ptr;
  logic [c_ADDR_W-1:0] r_rd_ptr;
  logic [c_LVL_W-1:0]  r_level;
  logic                r_overflow;
  logic                r_underflow;

  logic w_empty;
  logic w_full;
  logic w_push_acc;
  logic w_pop_acc;
  logic w_ovf_set;
  logic w_unf_set;

  // Status comes only from the registered level counter.
  assign w_empty = (r_level == '0);
  assign w_full  = (r_level == c_LVL_W'(DEPTH));

  // A push into a full buffer is still accepted when a pop frees the slot in
  // the same cycle (full implies non-empty since DEPTH >= 2). On an empty
  // buffer the pop is rejected even if a push arrives: no bypass path.
  assign w_push_acc = valid_out_interface & (~w_full | read_fifo_en) & ~flush;
  assign w_pop_acc  = read_fifo_en & ~w_empty & ~flush;
  assign w_ovf_set  = valid_out_interface & w_full & ~read_fifo_en & ~flush;
  assign w_unf_set  = read_fifo_en & w_empty & ~flush;

  // Storage is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_push_acc && !reset) begin
      r_mem[r_wr_ptr] <= out_interface;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ADDR_W'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + c_ADDR_W'(1);
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_level <= r_level + c_LVL_W'(1);
        2'b01:   r_level <= r_level - c_LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // Sticky flags: a set event in the same cycle as clear_flags wins. Flush
  // leaves the flags alone (its own push/pop are suppressed above).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clear_flags) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (clear_flags) begin
        r_underflow <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft_read
      // Head of the queue is always visible; a pop advances to the next one.
      assign out_fifo = r_mem[r_rd_ptr];
      assign rd_valid = ~w_empty;
    end else begin : g_reg_read
      logic [DATA_W-1:0] r_out;
      logic              r_rd_valid;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_out      <= '0;
          r_rd_valid <= 1'b0;
        end else if (flush) begin
          r_rd_valid <= 1'b0;
        end else if (w_pop_acc) begin
          r_out      <= r_mem[r_rd_ptr];
          r_rd_valid <= 1'b1;
        end else begin
          r_rd_valid <= 1'b0;
        end
      end

      assign out_fifo = r_out;
      assign rd_valid = r_rd_valid;
    end
  endgenerate

  assign empty         = w_empty;
  assign full          = w_full;
  assign ready_to_core = ~w_full;
  assign almost_full   = (r_level >= c_LVL_W'(AF_TH));
  assign level         = r_level;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_result_fifo_ctl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_result_fifo_ctl                                         |
// | Description : Self-checking bench for result_fifo_ctl. Instance A runs   |
// |               in first-word-fall-through mode, instance B in registered- |
// |               read mode. Expected data lives in scoreboard queues.       |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_result_fifo_ctl;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 8;
  localparam int AF_TH  = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Instance A (FWFT=1)
  logic              a_valid, a_pop, a_flush, a_clr;
  logic [DATA_W-1:0] a_data, a_out;
  logic              a_ready, a_rd_valid, a_empty, a_full, a_af, a_ovf, a_unf;
  logic [3:0]        a_level;

  // Instance B (FWFT=0)
  logic              b_valid, b_pop, b_flush, b_clr;
  logic [DATA_W-1:0] b_data, b_out;
  logic              b_ready, b_rd_valid, b_empty, b_full, b_af, b_ovf, b_unf;
  logic [3:0]        b_level;

  result_fifo_ctl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_TH(AF_TH), .FWFT(1)) u_dut_a (
    .clk(clk), .reset(reset),
    .valid_out_interface(a_valid), .out_interface(a_data), .ready_to_core(a_ready),
    .read_fifo_en(a_pop), .out_fifo(a_out), .rd_valid(a_rd_valid),
    .empty(a_empty), .full(a_full), .almost_full(a_af), .level(a_level),
    .flush(a_flush), .clear_flags(a_clr), .overflow(a_ovf), .underflow(a_unf)
  );

  result_fifo_ctl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_TH(AF_TH), .FWFT(0)) u_dut_b (
    .clk(clk), .reset(reset),
    .valid_out_interface(b_valid), .out_interface(b_data), .ready_to_core(b_ready),
    .read_fifo_en(b_pop), .out_fifo(b_out), .rd_valid(b_rd_valid),
    .empty(b_empty), .full(b_full), .almost_full(b_af), .level(b_level),
    .flush(b_flush), .clear_flags(b_clr), .overflow(b_ovf), .underflow(b_unf)
  );

  int checks   = 0;
  int failures = 0;

  logic [DATA_W-1:0] qa[$];
  logic [DATA_W-1:0] qb[$];
  int lvl_a = 0;
  int lvl_b = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One cycle on instance A. Data for an accepted pop is the FWFT head,
  // so it is compared before the edge.
  task automatic op_a(input bit v, input logic [DATA_W-1:0] d, input bit p,
                      input bit fl, input bit clr);
    logic [DATA_W-1:0] e;
    bit push_ok, pop_ok;
    push_ok = v && (lvl_a < DEPTH || p) && !fl;
    pop_ok  = p && (lvl_a > 0) && !fl;
    a_valid = v; a_data = d; a_pop = p; a_flush = fl; a_clr = clr;
    if (pop_ok) begin
      e = qa.pop_front();
      check("a_pop_data", 64'(a_out), 64'(e));
      check("a_pop_rd_valid", 64'(a_rd_valid), 64'd1);
    end
    @(posedge clk); #1;
    if (fl) begin
      qa.delete();
      lvl_a = 0;
    end else begin
      if (push_ok) qa.push_back(d);
      lvl_a = lvl_a + int'(push_ok) - int'(pop_ok);
    end
    a_valid = 1'b0; a_pop = 1'b0; a_flush = 1'b0; a_clr = 1'b0;
    check("a_level", 64'(a_level), 64'(lvl_a));
  endtask

  // One cycle on instance B. Registered read: data appears after the edge.
  task automatic op_b(input bit v, input logic [DATA_W-1:0] d, input bit p);
    logic [DATA_W-1:0] e;
    bit push_ok, pop_ok;
    push_ok = v && (lvl_b < DEPTH || p);
    pop_ok  = p && (lvl_b > 0);
    b_valid = v; b_data = d; b_pop = p;
    @(posedge clk); #1;
    if (pop_ok) begin
      e = qb.pop_front();
      check("b_pop_data", 64'(b_out), 64'(e));
      check("b_pop_rd_valid", 64'(b_rd_valid), 64'd1);
    end else begin
      check("b_idle_rd_valid", 64'(b_rd_valid), 64'd0);
    end
    if (push_ok) qb.push_back(d);
    lvl_b = lvl_b + int'(push_ok) - int'(pop_ok);
    b_valid = 1'b0; b_pop = 1'b0;
    check("b_level", 64'(b_level), 64'(lvl_b));
  endtask

  initial begin
    reset = 1'b1;
    a_valid = 0; a_data = '0; a_pop = 0; a_flush = 0; a_clr = 0;
    b_valid = 0; b_data = '0; b_pop = 0; b_flush = 0; b_clr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset state
    check("rst_level", 64'(a_level), 64'd0);
    check("rst_empty", 64'(a_empty), 64'd1);
    check("rst_full", 64'(a_full), 64'd0);
    check("rst_af", 64'(a_af), 64'd0);
    check("rst_ready", 64'(a_ready), 64'd1);
    check("rst_ovf", 64'(a_ovf), 64'd0);
    check("rst_unf", 64'(a_unf), 64'd0);
    check("rst_rd_valid", 64'(a_rd_valid), 64'd0);
    check("rst_b_out", 64'(b_out), 64'd0);
    check("rst_b_rd_valid", 64'(b_rd_valid), 64'd0);

    // Basic push/pop
    op_a(1, 32'h11, 0, 0, 0);
    op_a(1, 32'h22, 0, 0, 0);
    op_a(1, 32'h33, 0, 0, 0);
    check("basic_head", 64'(a_out), 64'h11);
    check("basic_rd_valid", 64'(a_rd_valid), 64'd1);
    repeat (3) op_a(0, '0, 1, 0, 0);
    check("basic_empty", 64'(a_empty), 64'd1);
    check("basic_rd_valid_low", 64'(a_rd_valid), 64'd0);

    // Fill, then overflow
    for (int i = 0; i < DEPTH; i++) op_a(1, 32'h100 + i, 0, 0, 0);
    check("fill_full", 64'(a_full), 64'd1);
    check("fill_ready", 64'(a_ready), 64'd0);
    op_a(1, 32'hDEAD, 0, 0, 0);
    check("ovf_set", 64'(a_ovf), 64'd1);
    check("ovf_full", 64'(a_full), 64'd1);
    check("ovf_unf_clear", 64'(a_unf), 64'd0);
    for (int i = 0; i < DEPTH; i++) op_a(0, '0, 1, 0, 0);
    check("drain_empty", 64'(a_empty), 64'd1);
    op_a(0, '0, 0, 0, 1);
    check("ovf_cleared", 64'(a_ovf), 64'd0);

    // Full: simultaneous push and pop
    for (int i = 0; i < DEPTH; i++) op_a(1, 32'h200 + i, 0, 0, 0);
    op_a(1, 32'hBEEF, 1, 0, 0);
    check("fullpp_full", 64'(a_full), 64'd1);
    check("fullpp_ovf", 64'(a_ovf), 64'd0);
    for (int i = 0; i < DEPTH; i++) op_a(0, '0, 1, 0, 0);
    check("fullpp_empty", 64'(a_empty), 64'd1);

    // Empty: simultaneous push and pop
    op_a(1, 32'h5A, 1, 0, 0);
    check("emptypp_unf", 64'(a_unf), 64'd1);
    check("emptypp_head", 64'(a_out), 64'h5A);
    check("emptypp_rd_valid", 64'(a_rd_valid), 64'd1);
    op_a(0, '0, 1, 0, 0);
    op_a(0, '0, 1, 0, 1);
    check("clr_vs_set_unf", 64'(a_unf), 64'd1);
    op_a(0, '0, 0, 0, 1);
    check("unf_cleared", 64'(a_unf), 64'd0);

    // Almost-full threshold and flush
    op_a(0, '0, 1, 0, 0);
    check("unf_reset_again", 64'(a_unf), 64'd1);
    for (int i = 0; i < AF_TH - 1; i++) op_a(1, 32'h300 + i, 0, 0, 0);
    check("af_below", 64'(a_af), 64'd0);
    op_a(1, 32'h3FF, 0, 0, 0);
    check("af_at", 64'(a_af), 64'd1);
    op_a(1, 32'h400, 1, 1, 0);
    check("flush_empty", 64'(a_empty), 64'd1);
    check("flush_af", 64'(a_af), 64'd0);
    check("flush_ovf", 64'(a_ovf), 64'd0);
    check("flush_unf", 64'(a_unf), 64'd1);
    op_a(1, 32'h77, 0, 0, 0);
    check("post_flush_head", 64'(a_out), 64'h77);

    // Registered-read instance
    op_b(1, 32'hA0, 0);
    op_b(1, 32'hA1, 0);
    check("b_out_before_pop", 64'(b_out), 64'd0);
    op_b(0, '0, 1);
    op_b(0, '0, 1);
    op_b(0, '0, 0);
    check("b_hold_out", 64'(b_out), 64'hA1);
    op_b(1, 32'hA2, 0);
    b_pop = 1'b1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; b_pop = 1'b0;
    qb.delete(); lvl_b = 0;
    check("b_rst_level", 64'(b_level), 64'd0);
    check("b_rst_empty", 64'(b_empty), 64'd1);
    check("b_rst_out", 64'(b_out), 64'd0);
    check("b_rst_rd_valid", 64'(b_rd_valid), 64'd0);
    check("b_rst_ready", 64'(b_ready), 64'd1);
    check("b_rst_flags", 64'({b_ovf, b_unf, b_full, b_af}), 64'd0);
    check("a_rst_level", 64'(a_level), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
